traceback_unit: RTL and testbench
=================================

// Module: traceback_unit
// PURPOSE
//  Consumer end of the PE-array score/pointer stream. During FILL it stores one 2-bit direction
//  pointer per DP cell and tracks the running maximum score and its cell. On fill_done it walks
//  the stored pointers back from the max cell and emits the local-alignment path as a
//  valid/ready op stream.
//  Sits between the systolic pe_unit array and the host/result interface.
// PARAMETERS
//  QLEN     4   query length (DP rows); index range 0..QLEN-1
//  RLEN     16  reference length (DP columns); index range 0..RLEN-1
//  SCORE_W  8   score width; scores are signed, matching the PE datapath
//  IW       $clog2(QLEN)  row index width (localparam)
//  JW       $clog2(RLEN)  column index width (localparam)
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high; clears all state
//  start        in   1        pulse; clears max and pointer-valid state, enters FILL
//  cell_valid   in   1        a cell result is present this cycle
//  cell_i       in   IW       row of the cell
//  cell_j       in   JW       column of the cell
//  cell_score   in   SCORE_W  cell score (signed)
//  cell_dir     in   2        0=STOP, 1=UP (i-1), 2=LEFT (j-1), 3=DIAG (i-1,j-1)
//  fill_done    in   1        pulse; all cells delivered, begin traceback
//  tb_valid     out  1        op beat valid
//  tb_ready     in   1        downstream accepts the beat
//  tb_op        out  2        encoding as cell_dir; STOP only on the final beat
//  tb_i         out  IW       row of the emitted cell
//  tb_j         out  JW       column of the emitted cell
//  tb_last      out  1        final beat of the path
//  max_score    out  SCORE_W  best score seen this FILL
//  max_i        out  IW       row of max_score
//  max_j        out  JW       column of max_score
//  busy         out  1        high in FILL, SEEK, EMIT
//  done         out  1        one-cycle pulse when the final beat is accepted
//  err          out  1        sticky protocol error; cleared by start or reset
// BEHAVIOUR
//  Reset: state IDLE; every output 0; max_score 0.
//  States: IDLE -start-> FILL -fill_done-> SEEK -> EMIT -(last beat accepted)-> IDLE.
//    start is honoured in any state: it aborts, clears state and enters FILL next cycle.
//  FILL:
//    - On cell_valid, write cell_dir to ptr_mem[cell_i][cell_j] at the clock edge.
//    - If $signed(cell_score) > $signed(max_score), update max_score/max_i/max_j on that edge.
//    - Strict compare: on a tie the earliest cell wins. Scores <= 0 never update the max.
//    - A rewrite of the same cell overwrites the pointer.
//  SEEK (entered only if max_score > 0): issue a read of ptr at cursor (i,j); cursor starts at
//  (max_i,max_j). RAM read latency is 1 cycle; EMIT presents the beat in the following cycle.
//  Latency: fill_done seen at edge N -> tb_valid high in cycle N+2.
//  If max_score == 0 at fill_done: skip SEEK and emit a single beat: op STOP, i=j=0, tb_last=1.
//  EMIT:
//    - tb_* are held stable while tb_valid && !tb_ready.
//    - On accept of a non-STOP op, move the cursor per op and return to SEEK.
//    - If the move would underflow (UP/DIAG at i=0, LEFT/DIAG at j=0), do not move.
//      Instead, the next beat is STOP at the current cursor with tb_last=1.
//    - A pointer of STOP read from RAM is emitted directly as the final beat (op STOP, tb_last=1).
//    - done pulses on the cycle after final-beat acceptance; the FSM returns to IDLE.
//  Errors, all of which set err:
//    - cell_valid outside FILL: ignored.
//    - fill_done outside FILL: ignored.
//    - cell_i >= QLEN or cell_j >= RLEN: write dropped.
//  The path length is bounded by QLEN+RLEN beats, so no timeout is needed.
//  Mid-operation reset: all outputs go to reset values immediately (asynchronous); the beat in
//  flight is lost. Pointer RAM contents are undefined after reset.
// STRUCTURE
//  Shared package sw_pkg:
//    - typedef dir_t {STOP,UP,LEFT,DIAG} = 2'd0..3, shared with the pe_unit array encoder
//    - typedef tb_state_t
//    - SCORE_W default
//  Sub-module tb_ptr_ram: QLEN*RLEN x 2 bits, 1 write port, 1 registered read port,
//  address = i*RLEN + j. The FSM, max tracker and cursor live in this module.
// TESTING (QLEN=4, RLEN=4)
//  1. reset mid-EMIT -> tb_valid=0, busy=0, max_score=0 in the same cycle; IDLE after release.
//  2. start; diagonal cells (k,k) with score 2k+2 and dir DIAG, (0,0) with STOP; fill_done
//     -> beats DIAG(3,3), DIAG(2,2), DIAG(1,1), STOP(0,0) with last; max=8 @(3,3); done pulse.
//  3. Scores 5 at (1,2) then 5 at (3,0) -> max_i=1, max_j=2 (tie keeps earliest).
//  4. Max cell (2,0) with ptr LEFT -> beat LEFT(2,0), then STOP(2,0) with last (j underflow).
//  5. tb_ready low for 3 cycles on beat 2 of test 2 -> tb_op/tb_i/tb_j stable; same sequence.
//  6. All scores 0 -> single STOP(0,0) last beat; then cell_valid in IDLE -> err=1 until start.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared direction/state types for the Smith-Waterman traceback path
package sw_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    UP   = 2'd1,
    LEFT = 2'd2,
    DIAG = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SEEK,
    S_EMIT
  } tb_state_t;

  localparam int SCORE_W_DEF = 8;

endpackage

// File: rtl/traceback_unit_if.sv
// rtl/traceback_unit_if.sv - cell input stream, op output stream and status of the traceback unit
interface traceback_unit_if
  import sw_pkg::*;
#(
  parameter int QLEN    = 4,
  parameter int RLEN    = 16,
  parameter int SCORE_W = SCORE_W_DEF
);
  localparam int IW = (QLEN > 1) ? $clog2(QLEN) : 1;
  localparam int JW = (RLEN > 1) ? $clog2(RLEN) : 1;

  logic                      start;
  logic                      cell_valid;
  logic [IW-1:0]             cell_i;
  logic [JW-1:0]             cell_j;
  logic signed [SCORE_W-1:0] cell_score;
  dir_t                      cell_dir;
  logic                      fill_done;
  logic                      tb_valid;
  logic                      tb_ready;
  dir_t                      tb_op;
  logic [IW-1:0]             tb_i;
  logic [JW-1:0]             tb_j;
  logic                      tb_last;
  logic signed [SCORE_W-1:0] max_score;
  logic [IW-1:0]             max_i;
  logic [JW-1:0]             max_j;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output start, cell_valid, cell_i, cell_j, cell_score, cell_dir, fill_done, tb_ready,
    input  tb_valid, tb_op, tb_i, tb_j, tb_last, max_score, max_i, max_j, busy, done, err
  );

  modport slave (
    input  start, cell_valid, cell_i, cell_j, cell_score, cell_dir, fill_done, tb_ready,
    output tb_valid, tb_op, tb_i, tb_j, tb_last, max_score, max_i, max_j, busy, done, err
  );
endinterface

// File: rtl/tb_ptr_ram.sv
// rtl/tb_ptr_ram.sv - 2-bit direction pointer store, one write port, one registered read port
module tb_ptr_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);
  logic [1:0] mem [DEPTH];

  // Array is deliberately left unreset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= 2'd0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/traceback_unit.sv
// rtl/traceback_unit.sv - stores DP pointers and max cell during fill, then walks the path back
module traceback_unit
  import sw_pkg::*;
#(
  parameter int QLEN    = 4,
  parameter int RLEN    = 16,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input logic             clk,
  input logic             reset,
  traceback_unit_if.slave bus
);
  localparam int IW    = (QLEN > 1) ? $clog2(QLEN) : 1;
  localparam int JW    = (RLEN > 1) ? $clog2(RLEN) : 1;
  localparam int CELLS = QLEN * RLEN;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  tb_state_t                 state, state_nx;
  logic [IW-1:0]             cur_i, max_i_q;
  logic [JW-1:0]             cur_j, max_j_q;
  logic signed [SCORE_W-1:0] max_q;
  logic [CELLS-1:0]          ptr_vld;
  logic                      rd_vld, force_stop, err_q, done_q;
  logic [1:0]                rd_data;
  logic [AW-1:0]             waddr, raddr;
  logic                      in_range, wr_en, accept, underflow;
  dir_t                      emit_op;

  assign in_range = (int'(bus.cell_i) < QLEN) && (int'(bus.cell_j) < RLEN);
  assign wr_en    = (state == S_FILL) && bus.cell_valid && in_range && !bus.start;
  assign waddr    = AW'(int'(bus.cell_i) * RLEN + int'(bus.cell_j));
  assign raddr    = AW'(int'(cur_i) * RLEN + int'(cur_j));
  assign accept   = (state == S_EMIT) && bus.tb_ready;

  tb_ptr_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (bus.cell_dir),
    .re    (state == S_SEEK),
    .raddr (raddr),
    .rdata (rd_data)
  );

  // Cells never written since start read back as STOP so stale pointers cannot extend a path.
  always_comb begin
    emit_op = (force_stop || !rd_vld) ? STOP : dir_t'(rd_data);
    underflow = 1'b0;
    case (emit_op)
      UP:      underflow = (cur_i == '0);
      LEFT:    underflow = (cur_j == '0);
      DIAG:    underflow = (cur_i == '0) || (cur_j == '0);
      default: underflow = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (bus.start) begin
      state_nx = S_FILL;
    end else begin
      case (state)
        S_FILL: if (bus.fill_done) state_nx = (max_q > 0) ? S_SEEK : S_EMIT;
        S_SEEK: state_nx = S_EMIT;
        S_EMIT: if (accept) begin
          if (emit_op == STOP)  state_nx = S_IDLE;
          else if (!underflow)  state_nx = S_SEEK;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0; max_i_q <= '0; max_j_q <= '0;
      cur_i <= '0; cur_j <= '0; ptr_vld <= '0;
      rd_vld <= 1'b0; force_stop <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
    end else if (bus.start) begin
      max_q <= '0; max_i_q <= '0; max_j_q <= '0;
      cur_i <= '0; cur_j <= '0; ptr_vld <= '0;
      rd_vld <= 1'b0; force_stop <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= accept && (emit_op == STOP);
      if (bus.cell_valid && (state != S_FILL || !in_range)) err_q <= 1'b1;
      if (bus.fill_done && state != S_FILL) err_q <= 1'b1;
      if (wr_en) begin
        ptr_vld[waddr] <= 1'b1;
        if (bus.cell_score > max_q) begin
          max_q   <= bus.cell_score;
          max_i_q <= bus.cell_i;
          max_j_q <= bus.cell_j;
        end
      end
      if (state == S_FILL && bus.fill_done) begin
        if (max_q > 0) begin
          cur_i <= max_i_q; cur_j <= max_j_q; force_stop <= 1'b0;
        end else begin
          cur_i <= '0; cur_j <= '0; force_stop <= 1'b1;
        end
      end
      if (state == S_SEEK) rd_vld <= ptr_vld[raddr];
      if (accept && emit_op != STOP) begin
        if (underflow) begin
          force_stop <= 1'b1;
        end else begin
          if (emit_op == UP || emit_op == DIAG)   cur_i <= cur_i - IW'(1);
          if (emit_op == LEFT || emit_op == DIAG) cur_j <= cur_j - JW'(1);
        end
      end
    end
  end

  assign bus.tb_valid  = (state == S_EMIT);
  assign bus.tb_op     = bus.tb_valid ? emit_op : STOP;
  assign bus.tb_i      = cur_i;
  assign bus.tb_j      = cur_j;
  assign bus.tb_last   = bus.tb_valid && (emit_op == STOP);
  assign bus.max_score = max_q;
  assign bus.max_i     = max_i_q;
  assign bus.max_j     = max_j_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_traceback_unit.sv
// tb/tb_traceback_unit.sv - directed and randomized checks of traceback_unit against a path model
module tb_traceback_unit;
  import sw_pkg::*;

  localparam int QLEN = 4;
  localparam int RLEN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traceback_unit_if #(.QLEN(QLEN), .RLEN(RLEN), .SCORE_W(8)) bus ();
  traceback_unit #(.QLEN(QLEN), .RLEN(RLEN), .SCORE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int op;
    int i;
    int j;
    int last;
  } beat_t;

  int    passes = 0;
  int    total  = 0;
  int    ref_dir [QLEN][RLEN];
  bit    ref_vld [QLEN][RLEN];
  int    ref_max, ref_mi, ref_mj;
  beat_t exp_q[$];

  task automatic check(input string name, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ref_max = 0; ref_mi = 0; ref_mj = 0;
    for (int i = 0; i < QLEN; i++)
      for (int j = 0; j < RLEN; j++) ref_vld[i][j] = 1'b0;
  endtask

  task automatic send_cell(input int i, input int j, input int score, input int d);
    logic [1:0] d2;
    d2 = 2'(d);
    bus.cell_valid = 1'b1;
    bus.cell_i = 2'(i);
    bus.cell_j = 2'(j);
    bus.cell_score = 8'(score);
    bus.cell_dir = dir_t'(d2);
    tick();
    bus.cell_valid = 1'b0;
    ref_dir[i][j] = d;
    ref_vld[i][j] = 1'b1;
    if (score > ref_max) begin
      ref_max = score; ref_mi = i; ref_mj = j;
    end
  endtask

  // Walk the stored pointers from the best cell, stopping on STOP or an out-of-matrix move.
  function automatic void build_expected();
    int i, j, d, ni, nj;
    exp_q.delete();
    if (ref_max <= 0) begin
      exp_q.push_back('{0, 0, 0, 1});
      return;
    end
    i = ref_mi; j = ref_mj;
    for (int n = 0; n <= QLEN + RLEN; n++) begin
      d = ref_vld[i][j] ? ref_dir[i][j] : 0;
      if (d == 0) begin
        exp_q.push_back('{0, i, j, 1});
        break;
      end
      exp_q.push_back('{d, i, j, 0});
      ni = (d == 1 || d == 3) ? i - 1 : i;
      nj = (d == 2 || d == 3) ? j - 1 : j;
      if (ni < 0 || nj < 0) begin
        exp_q.push_back('{0, i, j, 1});
        break;
      end
      i = ni; j = nj;
    end
  endfunction

  task automatic check_max(input string tag);
    check({tag, "_max_score"}, $signed(bus.max_score), ref_max);
    if (ref_max > 0) begin
      check({tag, "_max_i"}, bus.max_i, ref_mi);
      check({tag, "_max_j"}, bus.max_j, ref_mj);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 3 cycles on the second beat
  task automatic run_traceback(input string tag, input int mode);
    int k, stalls;
    bit hold, fin, rdy;
    int h_op, h_i, h_j;
    build_expected();
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    if (ref_max > 0) begin
      @(negedge clk);
      check({tag, "_seek_valid"}, bus.tb_valid, 0);
      tick();
    end
    k = 0; stalls = 0; hold = 0; fin = 0;
    h_op = 0; h_i = 0; h_j = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (mode == 1)      rdy = 1'($urandom_range(0, 1));
      else if (mode == 2) rdy = !(k == 1 && stalls < 3);
      else                rdy = 1'b1;
      bus.tb_ready = rdy;
      @(negedge clk);
      if (cyc == 0) check({tag, "_first_valid"}, bus.tb_valid, 1);
      if (bus.tb_valid) begin
        if (hold) begin
          check({tag, "_hold_op"}, bus.tb_op, h_op);
          check({tag, "_hold_i"}, bus.tb_i, h_i);
          check({tag, "_hold_j"}, bus.tb_j, h_j);
        end
        hold = !rdy; h_op = bus.tb_op; h_i = bus.tb_i; h_j = bus.tb_j;
        if (!rdy && mode == 2) stalls++;
        if (rdy) begin
          check({tag, "_extra_beat"}, int'(k < exp_q.size()), 1);
          if (k < exp_q.size()) begin
            check({tag, "_op"}, bus.tb_op, exp_q[k].op);
            check({tag, "_i"}, bus.tb_i, exp_q[k].i);
            check({tag, "_j"}, bus.tb_j, exp_q[k].j);
            check({tag, "_last"}, bus.tb_last, exp_q[k].last);
            if (exp_q[k].last != 0) fin = 1;
            k++;
          end
        end
      end else begin
        hold = 0;
      end
      tick();
    end
    bus.tb_ready = 1'b0;
    check({tag, "_beat_count"}, k, exp_q.size());
    if (fin) begin
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_idle_busy"}, bus.busy, 0);
      tick();
      check({tag, "_done_pulse"}, bus.done, 0);
    end
  endtask

  task automatic fill_diagonal();
    send_cell(0, 0, 2, 0);
    for (int k = 1; k < 4; k++) send_cell(k, k, 2 * k + 2, 3);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.cell_valid = 1'b0; bus.cell_i = '0; bus.cell_j = '0;
    bus.cell_score = '0; bus.cell_dir = STOP; bus.fill_done = 1'b0; bus.tb_ready = 1'b0;
    ref_max = 0; ref_mi = 0; ref_mj = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.tb_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_max", bus.max_score, 0);
    check("rst_err", bus.err, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    tick();

    // Diagonal path, then the same with a stalled second beat.
    do_start();
    fill_diagonal();
    check("diag_max_score", $signed(bus.max_score), 8);
    check("diag_max_i", bus.max_i, 3);
    check("diag_max_j", bus.max_j, 3);
    run_traceback("diag", 0);
    do_start();
    fill_diagonal();
    run_traceback("stall", 2);

    // Asynchronous reset in the middle of EMIT.
    do_start();
    fill_diagonal();
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    tick();
    check("mid_valid_before", bus.tb_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.tb_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_max", bus.max_score, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", bus.busy, 0);

    // Tie keeps the earliest cell.
    do_start();
    send_cell(1, 2, 5, 2);
    send_cell(3, 0, 5, 3);
    check("tie_max_i", bus.max_i, 1);
    check("tie_max_j", bus.max_j, 2);
    run_traceback("tie", 1);

    // LEFT at column 0 underflows into a STOP at the same cell.
    do_start();
    send_cell(2, 0, 7, 2);
    send_cell(1, 1, 3, 3);
    run_traceback("uflow", 0);

    // No positive score: single STOP beat, then a protocol error in IDLE.
    do_start();
    send_cell(1, 1, 0, 3);
    send_cell(2, 3, -4, 1);
    check_max("zero");
    run_traceback("zero", 0);
    check("err_clear", bus.err, 0);
    bus.cell_valid = 1'b1;
    tick();
    bus.cell_valid = 1'b0;
    check("err_set", bus.err, 1);
    tick();
    check("err_sticky", bus.err, 1);
    do_start();
    check("err_start_clr", bus.err, 0);
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    run_traceback("zero2", 1);

    // Randomized fills against the model.
    for (int r = 0; r < 8; r++) begin
      do_start();
      for (int c = 0; c < 14; c++)
        send_cell($urandom_range(0, QLEN - 1), $urandom_range(0, RLEN - 1),
                  int'($urandom_range(0, 50)) - 20, $urandom_range(0, 3));
      check_max("rnd");
      run_traceback("rnd", 1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
